// File: rtl/sc_mux10_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sc_mux10_arbiter
// Brief    : Round-robin arbiter driving a 10:1 mux select, with hold-limited
//            grants that rotate to waiting sources.
// Revision : 1.0
// ============================================================================
module sc_mux10_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       SC_MUXARB_CLOCK_50,
    input  logic       SC_MUXARB_RESET_InHigh,
    input  logic [9:0] SC_MUXARB_request_InBUS,
    input  logic       SC_MUXARB_sinkReady_In,
    output logic [3:0] SC_MUXARB_select_OutBUS,
    output logic [9:0] SC_MUXARB_grant_OutBUS,
    output logic       SC_MUXARB_valid_Out,
    output logic [3:0] SC_MUXARB_holdCount_OutBUS
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [4:0] c_maxHold = 5'(MAX_HOLD);

    state_t     r_state,     w_stateNext;
    logic [9:0] r_grant,     w_grantNext;
    logic [3:0] r_select,    w_selectNext;
    logic       r_valid,     w_validNext;
    logic [3:0] r_holdCount, w_holdNext;
    logic [3:0] r_lastPtr,   w_lastPtrNext;

    logic [9:0] w_others;
    logic       w_anyOther;
    logic       w_ownReq;
    logic       w_transfer;
    logic [4:0] w_countInc;
    logic [3:0] w_pick;

    // First set bit of req searching upward from ptr+1, wrapping 9 -> 0.
    function automatic logic [3:0] rrPick(input logic [9:0] req, input logic [3:0] ptr);
        logic [3:0] pick;
        logic       found;
        logic [4:0] idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            idx = {1'b0, ptr} + 5'(i);
            if (idx >= 5'd10) begin
                idx = idx - 5'd10;
            end
            if (!found && req[idx[3:0]]) begin
                pick  = idx[3:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // The granted bit is masked out, so in IDLE and on release this equals
    // the raw request vector; on rotation it excludes the current holder.
    assign w_others   = SC_MUXARB_request_InBUS & ~r_grant;
    assign w_anyOther = |w_others;
    assign w_ownReq   = |(SC_MUXARB_request_InBUS & r_grant);
    assign w_transfer = r_valid & SC_MUXARB_sinkReady_In;
    assign w_countInc = {1'b0, r_holdCount} + 5'd1;
    assign w_pick     = rrPick(w_others, r_lastPtr);

    always_comb begin
        w_stateNext   = r_state;
        w_grantNext   = r_grant;
        w_selectNext  = r_select;
        w_validNext   = r_valid;
        w_holdNext    = r_holdCount;
        w_lastPtrNext = r_lastPtr;

        case (r_state)
            IDLE: begin
                w_grantNext = 10'd0;
                w_validNext = 1'b0;
                w_holdNext  = 4'd0;
                if (w_anyOther) begin
                    w_stateNext   = GRANT;
                    w_grantNext   = 10'd1 << w_pick;
                    w_selectNext  = w_pick;
                    w_validNext   = 1'b1;
                    w_lastPtrNext = w_pick;
                end
            end
            GRANT: begin
                if (!w_ownReq) begin
                    // Release wins over any pending rotation.
                    w_holdNext = 4'd0;
                    if (w_anyOther) begin
                        w_grantNext   = 10'd1 << w_pick;
                        w_selectNext  = w_pick;
                        w_validNext   = 1'b1;
                        w_lastPtrNext = w_pick;
                    end else begin
                        w_stateNext = IDLE;
                        w_grantNext = 10'd0;
                        w_validNext = 1'b0;
                    end
                end else begin
                    w_validNext = 1'b1;
                    if (w_transfer) begin
                        if (w_countInc == c_maxHold) begin
                            w_holdNext = 4'd0;
                            if (w_anyOther) begin
                                w_grantNext   = 10'd1 << w_pick;
                                w_selectNext  = w_pick;
                                w_lastPtrNext = w_pick;
                            end
                        end else begin
                            w_holdNext = w_countInc[3:0];
                        end
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_grantNext = 10'd0;
                w_validNext = 1'b0;
                w_holdNext  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge SC_MUXARB_CLOCK_50) begin
        if (SC_MUXARB_RESET_InHigh) begin
            r_state     <= IDLE;
            r_grant     <= 10'd0;
            r_select    <= 4'd0;
            r_valid     <= 1'b0;
            r_holdCount <= 4'd0;
            r_lastPtr   <= 4'd9;
        end else begin
            r_state     <= w_stateNext;
            r_grant     <= w_grantNext;
            r_select    <= w_selectNext;
            r_valid     <= w_validNext;
            r_holdCount <= w_holdNext;
            r_lastPtr   <= w_lastPtrNext;
        end
    end

    assign SC_MUXARB_select_OutBUS    = r_select;
    assign SC_MUXARB_grant_OutBUS     = r_grant;
    assign SC_MUXARB_valid_Out        = r_valid;
    assign SC_MUXARB_holdCount_OutBUS = r_holdCount;

endmodule
`default_nettype wire
